mean_seq_ctrl: RTL and testbench

// Sequential controller that computes the byte mean of an N-entry ROM using one shared accumulator.

---
 rtl/mean_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mean_seq_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mean_seq_ctrl.sv
// Byte mean of an N-entry sync ROM via one shared accumulator; optional per-segment outputs under SEG_MEAN_OUT_EN.
// Latency: start accepted at edge E, done pulses in cycle E+N+3 (35 cycles for N=32).
// Backpressure: start honoured only while ready=1; requests during a run are dropped, not queued.
module mean_seq_ctrl #(
    parameter int DW   = 8,
    parameter int N    = 32,
    parameter int SEGS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DW-1:0]                 rom_data,
    output logic                          rom_rd,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] rom_addr,
    output logic                          ready,
    output logic                          done,
    output logic [DW-1:0]                 mean
`ifdef SEG_MEAN_OUT_EN
    ,
    output logic                          seg_valid,
    output logic [((SEGS > 1) ? $clog2(SEGS) : 1)-1:0] seg_idx,
    output logic [DW-1:0]                 seg_mean
`endif
);

    localparam int AW  = (N > 1) ? $clog2(N) : 1;
    localparam int L   = N / SEGS;
    localparam int LW  = $clog2(L);
    localparam int SW  = (SEGS > 1) ? $clog2(SEGS) : 1;
    localparam int SSH = $clog2(SEGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_FINAL,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            rom_rd_q, rom_rd_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic [DW-1:0]   mean_q, mean_d;
    logic            cap_q, cap_d;
    logic [AW-1:0]   cap_cnt_q, cap_cnt_d;
    logic [DW+LW-1:0] seg_acc_q, seg_acc_d;
    logic [DW+SW-1:0] msum_q, msum_d;

    logic [DW+LW-1:0] seg_sum;
    logic [DW-1:0]    seg_mean_w;
    logic             seg_last;

    // cap_q marks the cycle in which rom_data answers last cycle's read
    always_comb begin
        seg_sum    = seg_acc_q + (DW+LW)'(rom_data);
        seg_mean_w = DW'(seg_sum >> LW);
        seg_last   = cap_q && ((cap_cnt_q & AW'(L-1)) == AW'(L-1));
    end

    always_comb begin
        state_d    = state_q;
        rom_rd_d   = rom_rd_q;
        rom_addr_d = rom_addr_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        mean_d     = mean_q;
        cap_d      = rom_rd_q;
        cap_cnt_d  = cap_cnt_q;
        seg_acc_d  = seg_acc_q;
        msum_d     = msum_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    ready_d    = 1'b0;
                    rom_rd_d   = 1'b1;
                    rom_addr_d = '0;
                    cap_cnt_d  = '0;
                    seg_acc_d  = '0;
                    msum_d     = '0;
                end
            end
            S_FETCH: begin
                if (rom_addr_q == AW'(N-1)) begin
                    rom_rd_d = 1'b0;
                    state_d  = S_DRAIN;
                end else begin
                    rom_addr_d = rom_addr_q + 1'b1;
                end
            end
            S_DRAIN: state_d = S_FINAL;
            S_FINAL: begin
                mean_d  = DW'(msum_q >> SSH);
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                ready_d  = 1'b1;
                rom_rd_d = 1'b0;
            end
        endcase

        // Segment boundary: fold the completed mean in and restart the accumulator at zero
        if (cap_q) begin
            cap_cnt_d = cap_cnt_q + 1'b1;
            if (seg_last) begin
                seg_acc_d = '0;
                msum_d    = msum_q + (DW+SW)'(seg_mean_w);
            end else begin
                seg_acc_d = seg_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            mean_q     <= '0;
            cap_q      <= 1'b0;
            cap_cnt_q  <= '0;
            seg_acc_q  <= '0;
            msum_q     <= '0;
        end else begin
            state_q    <= state_d;
            rom_rd_q   <= rom_rd_d;
            rom_addr_q <= rom_addr_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            mean_q     <= mean_d;
            cap_q      <= cap_d;
            cap_cnt_q  <= cap_cnt_d;
            seg_acc_q  <= seg_acc_d;
            msum_q     <= msum_d;
        end
    end

    assign rom_rd   = rom_rd_q;
    assign rom_addr = rom_addr_q;
    assign ready    = ready_q;
    assign done     = done_q;
    assign mean     = mean_q;

`ifdef SEG_MEAN_OUT_EN
    logic            seg_valid_q, seg_valid_d;
    logic [SW-1:0]   seg_idx_q, seg_idx_d;
    logic [DW-1:0]   seg_mean_q, seg_mean_d;

    always_comb begin
        seg_valid_d = seg_last;
        seg_idx_d   = seg_idx_q;
        seg_mean_d  = seg_mean_q;
        if (seg_last) begin
            seg_idx_d  = SW'(cap_cnt_q >> LW);
            seg_mean_d = seg_mean_w;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_valid_q <= 1'b0;
            seg_idx_q   <= '0;
            seg_mean_q  <= '0;
        end else begin
            seg_valid_q <= seg_valid_d;
            seg_idx_q   <= seg_idx_d;
            seg_mean_q  <= seg_mean_d;
        end
    end

    assign seg_valid = seg_valid_q;
    assign seg_idx   = seg_idx_q;
    assign seg_mean  = seg_mean_q;
`endif

endmodule

// File: tb/tb_mean_seq_ctrl.sv
// Directed bench for mean_seq_ctrl with a behavioural 1-cycle-latency ROM.
module tb_mean_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] rom_data = 8'h00;
    logic       rom_rd;
    logic [4:0] rom_addr;
    logic       ready;
    logic       done;
    logic [7:0] mean;
`ifdef SEG_MEAN_OUT_EN
    logic       seg_valid;
    logic [0:0] seg_idx;
    logic [7:0] seg_mean;
    logic [8:0] seg_log[$];
`endif

    logic [7:0] rom [32];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

    mean_seq_ctrl #(.DW(8), .N(32), .SEGS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rom_data (rom_data),
        .rom_rd   (rom_rd),
        .rom_addr (rom_addr),
        .ready    (ready),
        .done     (done),
        .mean     (mean)
`ifdef SEG_MEAN_OUT_EN
        ,
        .seg_valid(seg_valid),
        .seg_idx  (seg_idx),
        .seg_mean (seg_mean)
`endif
    );

`ifdef SEG_MEAN_OUT_EN
    always @(negedge clk) if (seg_valid) seg_log.push_back({seg_idx, seg_mean});
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with ready=1; returns at the negedge after done.
    task automatic run_chk(input string tag, input logic [7:0] exp_mean,
                           input logic [7:0] old_mean, input bit keep_start);
        int addr_exp = 0;
        int done_cyc = -1;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_start) start = 1'b0;
        for (int c = 1; c <= 45 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (rom_rd) begin
                chk($sformatf("%s_addr%0d", tag, addr_exp), rom_addr, addr_exp);
                addr_exp++;
            end
            if (done) done_cyc = c;
            else if (c == 20) chk($sformatf("%s_mean_hold", tag), mean, old_mean);
        end
        chk($sformatf("%s_latency", tag), done_cyc, 35);
        chk($sformatf("%s_nreads", tag), addr_exp, 32);
        chk($sformatf("%s_mean", tag), mean, exp_mean);
        @(negedge clk);
        chk($sformatf("%s_done_pulse", tag), done, 0);
        chk($sformatf("%s_ready_after", tag), ready, 1);
        chk($sformatf("%s_mean_held", tag), mean, exp_mean);
    endtask

    initial begin
        int waited;
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 8'h40;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_rom_rd", rom_rd, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_mean", mean, 0);
        rst = 1'b1;
        @(negedge clk);

        // Constant 0x40
        run_chk("const40", 8'h40, 8'h00, 1'b0);

        // Half FF, half 01: must not wrap to 00
        for (int i = 0; i < 32; i++) rom[i] = (i < 16) ? 8'hFF : 8'h01;
        run_chk("ff01", 8'h80, 8'h40, 1'b0);

        // Ramp; seg means 7 and 23
        for (int i = 0; i < 32; i++) rom[i] = 8'(i);
`ifdef SEG_MEAN_OUT_EN
        seg_log.delete();
`endif
        run_chk("ramp", 8'd15, 8'h80, 1'b0);
`ifdef SEG_MEAN_OUT_EN
        chk("seg_count", seg_log.size(), 2);
        if (seg_log.size() == 2) begin
            chk("seg0", seg_log[0], {1'b0, 8'd7});
            chk("seg1", seg_log[1], {1'b1, 8'd23});
        end
`endif

        // start held high: one run per ready window, back-to-back restart
        for (int i = 0; i < 32; i++) rom[i] = 8'h10 + 8'(i);
        run_chk("held1", 8'h1F, 8'd15, 1'b1);
        for (int i = 0; i < 32; i++) rom[i] = 8'hC0;
        run_chk("held2", 8'hC0, 8'h1F, 1'b0);

        // Reset in the middle of FETCH
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waited = 0;
        while (!(rom_rd && rom_addr == 5'd10) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_reach_addr10", rom_addr, 10);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        chk("abort_mean", mean, 0);
        chk("abort_rom_rd", rom_rd, 0);
        chk("abort_addr", rom_addr, 0);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) rom[i] = (i < 16) ? 8'h20 : 8'h60;
        run_chk("post_abort", 8'h40, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
